// File: rtl/div_pkg.sv
// Shared definitions for the radix-2 restoring divider: widths, iteration count, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two's-complement negation at the divider's operand width.
    function automatic logic [DIV_WIDTH-1:0] twos_neg(input logic [DIV_WIDTH-1:0] v);
        return ~v + DIV_WIDTH'(1);
    endfunction

endpackage

// File: rtl/radix2_divider.sv
// Iterative radix-2 restoring divider, unsigned or two's-complement selected by SIGNED.
// Latency: result strobe 33 edges after accept; next accept possible 35 edges after accept.
// Backpressure: both tready high only while idle; output is a one-cycle strobe with no ready.
module radix2_divider
    import div_pkg::*;
#(
    parameter int unsigned SIGNED = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
    input  logic                   s_axis_dividend_tvalid,
    output logic                   s_axis_dividend_tready,
    input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
    input  logic                   s_axis_divisor_tvalid,
    output logic                   s_axis_divisor_tready,
    output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata,
    output logic                   m_axis_dout_tvalid
);

    div_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    // Holds the dividend magnitude at accept; quotient bits shift in from the bottom.
    logic [DIV_WIDTH-1:0]   quo_q, quo_d;
    logic [DIV_WIDTH-1:0]   dvs_q, dvs_d;
    logic [DIV_WIDTH-1:0]   rem_q, rem_d;
    logic                   dvd_neg_q, dvd_neg_d;
    logic                   quo_neg_q, quo_neg_d;
    logic [2*DIV_WIDTH-1:0] dout_q, dout_d;
    logic                   vld_q, vld_d;

    logic                   accept;
    logic                   dvd_sign, dvs_sign;
    logic [DIV_WIDTH-1:0]   dvd_mag, dvs_mag;
    logic [DIV_WIDTH:0]     part, diff;
    logic                   ge;
    logic [DIV_WIDTH-1:0]   quo_fix, rem_fix;

    assign accept = (state_q == IDLE) && s_axis_dividend_tvalid && s_axis_divisor_tvalid;

    // A zero divisor has a clear MSB, so it naturally counts as non-negative.
    assign dvd_sign = (SIGNED != 0) && s_axis_dividend_tdata[DIV_WIDTH-1];
    assign dvs_sign = (SIGNED != 0) && s_axis_divisor_tdata[DIV_WIDTH-1];
    assign dvd_mag  = dvd_sign ? twos_neg(s_axis_dividend_tdata) : s_axis_dividend_tdata;
    assign dvs_mag  = dvs_sign ? twos_neg(s_axis_divisor_tdata) : s_axis_divisor_tdata;

    // Partial remainder is kept below the divisor (or is a dividend prefix when dividing
    // by zero), so the 33-bit difference never overflows and its MSB is the borrow.
    assign part = {rem_q, quo_q[DIV_WIDTH-1]};
    assign diff = part - {1'b0, dvs_q};
    assign ge   = ~diff[DIV_WIDTH];

    assign quo_fix = quo_neg_q ? twos_neg(quo_q) : quo_q;
    assign rem_fix = dvd_neg_q ? twos_neg(rem_q) : rem_q;

    assign s_axis_dividend_tready = (state_q == IDLE);
    assign s_axis_divisor_tready  = (state_q == IDLE);
    assign m_axis_dout_tdata      = dout_q;
    assign m_axis_dout_tvalid     = vld_q;

    // Next-state and datapath update: capture at accept, one shift-subtract per CALC cycle,
    // sign fix-up into the output register in FIX, strobe during DONE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        dvd_neg_d = dvd_neg_q;
        quo_neg_d = quo_neg_q;
        dout_d    = dout_q;
        vld_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    quo_d     = dvd_mag;
                    dvs_d     = dvs_mag;
                    rem_d     = '0;
                    cnt_d     = '0;
                    dvd_neg_d = dvd_sign;
                    quo_neg_d = dvd_sign ^ dvs_sign;
                    state_d   = CALC;
                end
            end
            CALC: begin
                rem_d = ge ? diff[DIV_WIDTH-1:0] : part[DIV_WIDTH-1:0];
                quo_d = {quo_q[DIV_WIDTH-2:0], ge};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                dout_d  = {quo_fix, rem_fix};
                vld_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            dvd_neg_q <= 1'b0;
            quo_neg_q <= 1'b0;
            dout_q    <= '0;
            vld_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            dvd_neg_q <= dvd_neg_d;
            quo_neg_q <= quo_neg_d;
            dout_q    <= dout_d;
            vld_q     <= vld_d;
        end
    end

endmodule

// File: tb/tb_radix2_divider.sv
// Self-checking bench: unsigned and signed divider instances driven in lockstep.
// Latency: checks result strobe at accept+33 and re-accept at accept+35.
// Backpressure: checks tready low while busy and lone-tvalid rejection.
module tb_radix2_divider;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] dd, sd;
    logic        dv, sv;

    logic        rdy_dd_u, rdy_ds_u, vld_u;
    logic [63:0] dout_u;
    logic        rdy_dd_s, rdy_ds_s, vld_s;
    logic [63:0] dout_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    radix2_divider #(.SIGNED(0)) u_div_u (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tdata(dd), .s_axis_dividend_tvalid(dv), .s_axis_dividend_tready(rdy_dd_u),
        .s_axis_divisor_tdata(sd),  .s_axis_divisor_tvalid(sv),  .s_axis_divisor_tready(rdy_ds_u),
        .m_axis_dout_tdata(dout_u), .m_axis_dout_tvalid(vld_u)
    );

    radix2_divider #(.SIGNED(1)) u_div_s (
        .clk(clk), .resetn(resetn),
        .s_axis_dividend_tdata(dd), .s_axis_dividend_tvalid(dv), .s_axis_dividend_tready(rdy_dd_s),
        .s_axis_divisor_tdata(sd),  .s_axis_divisor_tvalid(sv),  .s_axis_divisor_tready(rdy_ds_s),
        .m_axis_dout_tdata(dout_s), .m_axis_dout_tvalid(vld_s)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic, truncating division, remainder follows the dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        longint sa, sb, q, r;
        if (b == 32'd0) begin
            if (sgn && a[31]) return {32'h00000001, a};
            return {32'hFFFFFFFF, a};
        end
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic logic rdy_all();
        return rdy_dd_u & rdy_ds_u & rdy_dd_s & rdy_ds_s;
    endfunction

    function automatic logic rdy_any();
        return rdy_dd_u | rdy_ds_u | rdy_dd_s | rdy_ds_s;
    endfunction

    // Entered and left at a negedge with both DUTs idle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string tag,
                          output logic [63:0] got_u, output logic [63:0] got_s);
        int first_u, first_s, pulses_u, pulses_s, busy_rdy;
        logic [63:0] exp_u, exp_s;
        exp_u = ref_div(a, b, 1'b0);
        exp_s = ref_div(a, b, 1'b1);
        first_u = 0; first_s = 0; pulses_u = 0; pulses_s = 0; busy_rdy = 0;
        got_u = '0; got_s = '0;
        dd = a; sd = b; dv = 1'b1; sv = 1'b1;
        chk({tag, "/rdy_idle"}, rdy_all(), 1);
        @(negedge clk);
        dv = 1'b0; sv = 1'b0; dd = $urandom; sd = $urandom;
        for (int n = 1; n <= 36; n++) begin
            if (vld_u) begin pulses_u++; if (first_u == 0) first_u = n; end
            if (vld_s) begin pulses_s++; if (first_s == 0) first_s = n; end
            if (n <= 34 && rdy_any()) busy_rdy++;
            if (n == 34) begin
                got_u = dout_u;
                got_s = dout_s;
                chk({tag, "/dout_u"}, dout_u, exp_u);
                chk({tag, "/dout_s"}, dout_s, exp_s);
            end
            if (n == 36) begin
                chk({tag, "/held_u"}, dout_u, exp_u);
                chk({tag, "/held_s"}, dout_s, exp_s);
            end
            @(negedge clk);
        end
        chk({tag, "/lat_u"}, 64'(first_u - 1), 33);
        chk({tag, "/lat_s"}, 64'(first_s - 1), 33);
        chk({tag, "/pulses"}, 64'(pulses_u + pulses_s), 2);
        chk({tag, "/busy_rdy"}, 64'(busy_rdy), 0);
    endtask

    // Both tvalid held high with fresh data every cycle.
    task automatic back_to_back();
        logic [31:0] a_arr [0:70];
        logic [31:0] b_arr [0:70];
        int busy, pulses;
        busy = 0; pulses = 0;
        for (int n = 0; n <= 70; n++) begin
            a_arr[n] = $urandom;
            b_arr[n] = $urandom_range(1, 1000);
        end
        dv = 1'b1; sv = 1'b1;
        for (int n = 0; n <= 70; n++) begin
            dd = a_arr[n]; sd = b_arr[n];
            if (vld_u) pulses++;
            if (n >= 1 && n <= 34 && rdy_any()) busy++;
            if (n == 34) begin
                chk("b2b/first_u", dout_u, ref_div(a_arr[0], b_arr[0], 1'b0));
                chk("b2b/first_s", dout_s, ref_div(a_arr[0], b_arr[0], 1'b1));
            end
            if (n == 35) chk("b2b/rdy_at_35", rdy_all(), 1);
            if (n == 69) begin
                chk("b2b/second_vld", vld_u & vld_s, 1);
                chk("b2b/second_u", dout_u, ref_div(a_arr[35], b_arr[35], 1'b0));
                chk("b2b/second_s", dout_s, ref_div(a_arr[35], b_arr[35], 1'b1));
                dv = 1'b0; sv = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b/busy_rdy", 64'(busy), 0);
        chk("b2b/pulses", 64'(pulses), 2);
        chk("b2b/idle_after", rdy_all(), 1);
    endtask

    task automatic lone_valid(input bit dividend_side, input string tag);
        int bad;
        bad = 0;
        dd = $urandom; sd = $urandom_range(1, 50);
        dv = dividend_side; sv = !dividend_side;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (!rdy_all()) bad++;
            if (vld_u | vld_s) bad++;
            dd = $urandom;
        end
        dv = 1'b0; sv = 1'b0;
        chk(tag, 64'(bad), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [63:0] gu, gs;
        logic [31:0] a, b;
        int pulses;

        resetn = 1'b0; dv = 1'b0; sv = 1'b0; dd = '0; sd = '0;
        repeat (3) @(negedge clk);
        chk("reset/rdy", rdy_all(), 1);
        chk("reset/vld", vld_u | vld_s, 0);
        chk("reset/dout_u", dout_u, 64'd0);
        chk("reset/dout_s", dout_s, 64'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, "u_100_7", gu, gs);
        chk("u_100_7/spec", gu, 64'h0000000E_00000002);
        run_op(32'hFFFFFFF9, 32'd2, "s_m7_2", gu, gs);
        chk("s_m7_2/spec", gs, 64'hFFFFFFFD_FFFFFFFF);
        run_op(32'd7, 32'hFFFFFFFE, "s_7_m2", gu, gs);
        chk("s_7_m2/spec", gs, 64'hFFFFFFFD_00000001);
        run_op(32'h80000000, 32'hFFFFFFFF, "s_min_m1", gu, gs);
        chk("s_min_m1/spec", gs, 64'h80000000_00000000);
        run_op(32'hFFFFFFFB, 32'd0, "s_m5_0", gu, gs);
        chk("s_m5_0/spec", gs, 64'h00000001_FFFFFFFB);
        run_op(32'd5, 32'd0, "u_5_0", gu, gs);
        chk("u_5_0/spec", gu, 64'hFFFFFFFF_00000005);

        lone_valid(1'b1, "lone_dividend");
        lone_valid(1'b0, "lone_divisor");
        @(negedge clk);
        chk("lone/still_idle", rdy_all(), 1);

        back_to_back();

        // Reset during CALC: accept, then pull resetn low at the tenth edge after accept.
        dd = 32'd20; sd = 32'd3; dv = 1'b1; sv = 1'b1;
        @(negedge clk);
        dv = 1'b0; sv = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        chk("midreset/rdy", rdy_all(), 1);
        chk("midreset/dout_u", dout_u, 64'd0);
        chk("midreset/dout_s", dout_s, 64'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            if (vld_u | vld_s) pulses++;
            @(negedge clk);
        end
        chk("midreset/no_pulse", 64'(pulses), 0);
        run_op(32'd9, 32'd3, "u_9_3", gu, gs);
        chk("u_9_3/spec", gu, 64'h00000003_00000000);

        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                3: begin a = 32'h80000000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1; end
                default: b = $urandom;
            endcase
            run_op(a, b, $sformatf("rnd%0d", i), gu, gs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/radix2_divider.md
RADIX2_DIVIDER -- requirements
Module: radix2_divider

Interface
REQ-001 SHALL have parameter SIGNED, default 0, meaning 0 = unsigned operands, 1 = two's-complement operands.
REQ-002 SHALL have input clk, 1 bit: rising-edge clock.
REQ-003 SHALL have input resetn, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have input s_axis_dividend_tdata, 32 bits: dividend.
REQ-005 SHALL have input s_axis_dividend_tvalid, 1 bit: dividend valid.
REQ-006 SHALL have output s_axis_dividend_tready, 1 bit: dividend accept.
REQ-007 SHALL have input s_axis_divisor_tdata, 32 bits: divisor.
REQ-008 SHALL have input s_axis_divisor_tvalid, 1 bit: divisor valid.
REQ-009 SHALL have output s_axis_divisor_tready, 1 bit: divisor accept.
REQ-010 SHALL have output m_axis_dout_tdata, 64 bits: [63:32] quotient, [31:0] remainder.
REQ-011 SHALL have output m_axis_dout_tvalid, 1 bit: one-cycle result strobe; there is no output ready.

Function
REQ-012 SHALL use states IDLE, CALC, FIX and DONE, with the following transitions.
- IDLE to CALC on accept.
- CALC to FIX after the 32nd iteration.
- FIX to DONE, then DONE to IDLE, unconditionally.
REQ-013 SHALL drive both tready outputs high only in IDLE, identical every cycle.
REQ-014 SHALL accept an operand pair only at an edge where state is IDLE and both tvalid inputs are high; a single tvalid high SHALL be ignored with no partial capture.
REQ-015 SHALL latch both operands at the accept edge, and SHALL ignore later input changes until the next accept.
REQ-016 SHALL, when SIGNED=1, convert operands to 32-bit magnitudes and record the dividend sign and the quotient sign (XOR of the operand signs, with divisor 0 counted as non-negative).
REQ-017 SHALL, when SIGNED=0, use operands directly as magnitudes.
REQ-018 SHALL perform one restoring shift-subtract iteration per clock in CALC, under a 6-bit iteration counter cleared at accept; subtraction SHALL be 33-bit so that no carry is lost.
REQ-019 SHALL, in FIX, apply sign correction and register the result into m_axis_dout_tdata.
- Quotient negated when the quotient sign is set.
- Remainder negated when the dividend sign is set.
- Quotient truncates toward zero; remainder takes the dividend's sign.
REQ-020 SHALL assert m_axis_dout_tvalid only in DONE: exactly one cycle, starting 33 edges after the accept edge. The next accept is possible at the edge 35 after it.
REQ-021 SHALL hold m_axis_dout_tdata stable from FIX until the next FIX.
REQ-022 SHALL, on divide by zero with SIGNED=0, give quotient 0xFFFFFFFF and remainder = dividend.
REQ-023 SHALL, on divide by zero with SIGNED=1, give quotient 0xFFFFFFFF for a non-negative dividend or 0x00000001 for a negative dividend, and remainder = dividend.
REQ-024 SHALL, for SIGNED=1 with 0x80000000 / 0xFFFFFFFF, give quotient 0x80000000 and remainder 0.
REQ-025 SHALL keep the latency data-independent: no early termination.

Reset
REQ-026 SHALL, while resetn is low at an edge, set state IDLE, counter 0, m_axis_dout_tvalid 0, m_axis_dout_tdata 0, and clear all working registers.
REQ-027 SHALL, on reset in CALC, FIX or DONE, discard the operation: no tvalid pulse, and tready high in the first cycle after reset is released.

Structure
REQ-028 SHALL place the state encoding, DIV_WIDTH=32 and DIV_ITERS=32 in the shared package div_pkg.
REQ-029 SHALL be one flat module with no sub-module; signed and unsigned instances differ only by SIGNED.

Verification
REQ-030 SHALL check SIGNED=0, 100 / 7 -> tdata 0x0000000E_00000002, tvalid high exactly at accept+33, one cycle.
REQ-031 SHALL check SIGNED=1, -7 / 2 -> 0xFFFFFFFD_FFFFFFFF, and 7 / -2 -> 0xFFFFFFFD_00000001.
REQ-032 SHALL check SIGNED=1, 0x80000000 / 0xFFFFFFFF -> 0x80000000_00000000; and -5 / 0 -> 0x00000001_FFFFFFFB.
REQ-033 SHALL check SIGNED=0, 5 / 0 -> 0xFFFFFFFF_00000005; and dividend tvalid alone held high for 10 cycles -> no accept, tready stays high.
REQ-034 SHALL check both tvalid held high continuously with changing data -> tready low through CALC, FIX and DONE, and the second pair accepted at accept+35 with the correct result.
REQ-035 SHALL check resetn low for 1 cycle at CALC iteration 10 -> no tvalid pulse, tdata 0, tready high next cycle, and the next 9 / 3 gives 0x00000003_00000000.
